// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the dual-core memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {IDLE, SNOOP, WB, ACCESS, RESP} arb_state_e;

    // 0 = core 1, 1 = core 2
    typedef logic core_id_t;

    localparam int unsigned SNOOP_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; the parent holds the "last served" register.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  core_id_t   i_last,
    output logic [1:0] o_grant,
    output core_id_t   o_gnt_id
);

    always_comb begin
        o_grant  = 2'b00;
        o_gnt_id = 1'b0;
        unique case (i_req)
            2'b01: begin
                o_grant  = 2'b01;
                o_gnt_id = 1'b0;
            end
            2'b10: begin
                o_grant  = 2'b10;
                o_gnt_id = 1'b1;
            end
            2'b11: begin
                o_gnt_id = ~i_last;
                o_grant  = i_last ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory port for two cores: round-robin grant, snoop the other core, copy back, access.
// Optional performance counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c1_req,
    input  logic              c1_wr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_stall,
    output logic              c1_done,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_snoop,
    input  logic              c1_dirty,
    input  logic [DATA_W-1:0] c1_cb_data,
    input  logic              c2_req,
    input  logic              c2_wr,
    input  logic [ADDR_W-1:0] c2_addr,
    input  logic [DATA_W-1:0] c2_wdata,
    output logic              c2_stall,
    output logic              c2_done,
    output logic [DATA_W-1:0] c2_rdata,
    output logic              c2_snoop,
    input  logic              c2_dirty,
    input  logic [DATA_W-1:0] c2_cb_data,
    output logic              snoop_wr,
    output logic [ADDR_W-1:0] snoop_addr,
    output logic              mem_rd,
    output logic              main_mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [31:0]       perf_grants_1,
    output logic [31:0]       perf_grants_2,
    output logic [31:0]       perf_copybacks
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e        r_state;
    core_id_t          r_owner;
    core_id_t          r_rr_last;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_c1_snoop, r_c2_snoop, r_snoop_wr;
    logic [ADDR_W-1:0] r_snoop_addr;
    logic              r_mem_rd, r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_c1_done, r_c2_done;
    logic [DATA_W-1:0] r_c1_rdata, r_c2_rdata;

    logic [1:0]        w_grant;
    core_id_t          w_gnt_id;
    logic              w_any;
    logic              w_req_wr;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_other_dirty;
    logic [DATA_W-1:0] w_other_cb;
    logic              w_cnt_zero;

    rr_arbiter2 u_rr (
        .i_req    ({c2_req, c1_req}),
        .i_last   (r_rr_last),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id)
    );

    assign w_any         = |w_grant;
    assign w_req_wr      = w_gnt_id ? c2_wr    : c1_wr;
    assign w_req_addr    = w_gnt_id ? c2_addr  : c1_addr;
    assign w_req_wdata   = w_gnt_id ? c2_wdata : c1_wdata;
    // The probed core is always the one that did not win the grant.
    assign w_other_dirty = r_owner ? c1_dirty   : c2_dirty;
    assign w_other_cb    = r_owner ? c1_cb_data : c2_cb_data;
    assign w_cnt_zero    = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_rr_last    <= 1'b1;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_c1_snoop   <= 1'b0;
            r_c2_snoop   <= 1'b0;
            r_snoop_wr   <= 1'b0;
            r_snoop_addr <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_c1_done    <= 1'b0;
            r_c2_done    <= 1'b0;
            r_c1_rdata   <= '0;
            r_c2_rdata   <= '0;
        end else begin
            r_c1_snoop   <= 1'b0;
            r_c2_snoop   <= 1'b0;
            r_snoop_wr   <= 1'b0;
            r_snoop_addr <= '0;
            r_c1_done    <= 1'b0;
            r_c2_done    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_gnt_id;
                        r_wr         <= w_req_wr;
                        r_addr       <= w_req_addr;
                        r_wdata      <= w_req_wdata;
                        r_c1_snoop   <= w_gnt_id;
                        r_c2_snoop   <= ~w_gnt_id;
                        r_snoop_wr   <= w_req_wr;
                        r_snoop_addr <= w_req_addr;
                        r_cnt        <= CNT_W'(SNOOP_CYCLES - 1);
                        r_state      <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_other_dirty) begin
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= w_other_cb;
                        r_cnt      <= CNT_W'(MEM_LAT - 1);
                        r_state    <= WB;
                    end else begin
                        r_mem_rd   <= ~r_wr;
                        r_mem_wr   <= r_wr;
                        r_mem_addr <= r_addr;
                        r_mem_data <= r_wr ? r_wdata : '0;
                        r_cnt      <= CNT_W'(MEM_LAT - 1);
                        r_state    <= ACCESS;
                    end
                end
                WB: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_mem_rd   <= ~r_wr;
                        r_mem_wr   <= r_wr;
                        r_mem_addr <= r_addr;
                        r_mem_data <= r_wr ? r_wdata : '0;
                        r_cnt      <= CNT_W'(MEM_LAT - 1);
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_mem_rd   <= 1'b0;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= '0;
                        r_mem_data <= '0;
                        if (!r_wr && !r_owner) r_c1_rdata <= mem_data_out;
                        if (!r_wr &&  r_owner) r_c2_rdata <= mem_data_out;
                        r_c1_done  <= ~r_owner;
                        r_c2_done  <= r_owner;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_rr_last <= r_owner;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c1_stall    = c1_req & ~((r_state == RESP) & (r_owner == 1'b0));
    assign c2_stall    = c2_req & ~((r_state == RESP) & (r_owner == 1'b1));
    assign c1_done     = r_c1_done;
    assign c2_done     = r_c2_done;
    assign c1_rdata    = r_c1_rdata;
    assign c2_rdata    = r_c2_rdata;
    assign c1_snoop    = r_c1_snoop;
    assign c2_snoop    = r_c2_snoop;
    assign snoop_wr    = r_snoop_wr;
    assign snoop_addr  = r_snoop_addr;
    assign mem_rd      = r_mem_rd;
    assign main_mem_wr = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_g1, r_perf_g2, r_perf_cb;
    logic        w_grant_evt, w_wb_evt;

    assign w_grant_evt = (r_state == IDLE) && w_any;
    assign w_wb_evt    = (r_state == SNOOP) && w_cnt_zero && w_other_dirty;

    // Saturating counters: stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_g1 <= '0;
            r_perf_g2 <= '0;
            r_perf_cb <= '0;
        end else begin
            if (w_grant_evt && !w_gnt_id && (r_perf_g1 != '1)) r_perf_g1 <= r_perf_g1 + 32'd1;
            if (w_grant_evt &&  w_gnt_id && (r_perf_g2 != '1)) r_perf_g2 <= r_perf_g2 + 32'd1;
            if (w_wb_evt && (r_perf_cb != '1))                 r_perf_cb <= r_perf_cb + 32'd1;
        end
    end

    assign perf_grants_1  = r_perf_g1;
    assign perf_grants_2  = r_perf_g2;
    assign perf_copybacks = r_perf_cb;
`else
    assign perf_grants_1  = '0;
    assign perf_grants_2  = '0;
    assign perf_copybacks = '0;
`endif

endmodule
